// File: rtl/datapath_pkg.sv
// Shared types for the dispatch stage.
//   fu_e       : functional-unit index (ALU, LD_ST, BRANCH, matrix LD/ST, GEMM)
//   tag_t      : producer tag. A unit's tag is its index + 1, and tag 0 means
//                "value available".
//   disp_pkt_t : register fields forwarded with a dispatched instruction
//   S_*/M_*    : scalar and matrix status-table geometry
package datapath_pkg;

  localparam int NUM_FU  = 5;
  localparam int TAG_W   = 3;
  localparam int S_DEPTH = 32;
  localparam int S_IDX_W = 5;
  localparam int M_DEPTH = 16;
  localparam int M_IDX_W = 4;

  typedef enum logic [2:0] {
    FU_ALU    = 3'd0,
    FU_LDST   = 3'd1,
    FU_BRANCH = 3'd2,
    FU_MLDST  = 3'd3,
    FU_GEMM   = 3'd4
  } fu_e;

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic               wen;
    logic [S_IDX_W-1:0] rd;
    logic [S_IDX_W-1:0] rs1;
    logic [S_IDX_W-1:0] rs2;
    logic [M_IDX_W-1:0] md;
    logic [M_IDX_W-1:0] ms1;
    logic [M_IDX_W-1:0] ms2;
    logic [M_IDX_W-1:0] ms3;
  } disp_pkt_t;

  function automatic tag_t fu_tag(input logic [2:0] fu);
    return tag_t'(fu + 3'd1);
  endfunction

  // Matrix units write the matrix table; every other unit writes the scalar one.
  function automatic logic fu_is_matrix(input logic [2:0] fu);
    return (fu == FU_MLDST) || (fu == FU_GEMM);
  endfunction

endpackage

// File: rtl/reg_status_table.sv
// Register status table: one producer tag per architectural register.
// Ports:
//   CLK, nRST             : clock, async active-low reset (all entries -> 0)
//   flush                 : synchronous clear of every entry (beats set/clear)
//   ra/rb/rc_idx -> *_tag : three source read ports
//   set_en/idx/tag        : install a new producer tag; set_busy reports
//                           whether set_idx is still owned after this cycle's clear
//   clr_en/idx/tag        : writeback; clears only if the stored tag matches
// Reads see this cycle's writeback (bypass). A set to the entry being cleared
// in the same cycle keeps the new tag. With ZERO_REG, entry 0 is hard-wired to 0.
module reg_status_table
  import datapath_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int IDX_W    = 5,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic [IDX_W-1:0] ra_idx,
  input  logic [IDX_W-1:0] rb_idx,
  input  logic [IDX_W-1:0] rc_idx,
  output tag_t             ra_tag,
  output tag_t             rb_tag,
  output tag_t             rc_tag,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_idx,
  input  tag_t             set_tag,
  output logic             set_busy,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx,
  input  tag_t             clr_tag
);

  tag_t             entries  [DEPTH];
  logic [IDX_W-1:0] look_idx [4];
  tag_t             look_tag [4];

  // Port 3 is the destination lookup used for the WAW check.
  // NOTE: every combinational output is assigned before any condition, so no latch can be inferred.
  always_comb begin
    look_idx[0] = ra_idx;
    look_idx[1] = rb_idx;
    look_idx[2] = rc_idx;
    look_idx[3] = set_idx;
    for (int p = 0; p < 4; p++) begin
      look_tag[p] = entries[look_idx[p]];
      if (clr_en && (clr_idx == look_idx[p]) && (entries[look_idx[p]] == clr_tag))
        look_tag[p] = '0;
      if (ZERO_REG && (look_idx[p] == '0))
        look_tag[p] = '0;
    end
  end

  assign ra_tag   = look_tag[0];
  assign rb_tag   = look_tag[1];
  assign rc_tag   = look_tag[2];
  assign set_busy = (look_tag[3] != '0);

  // NOTE: the table is reset entry by entry; a stale non-zero tag after reset would stall forever.
  // NOTE: sequential state uses non-blocking assignments so every entry samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ZERO_REG && (i == 0))
          entries[i] <= '0;
        else if (set_en && (set_idx == IDX_W'(i)))
          entries[i] <= set_tag;
        else if (clr_en && (clr_idx == IDX_W'(i)) && (entries[i] == clr_tag))
          entries[i] <= '0;
      end
    end
  end

endmodule

// File: rtl/dispatch.sv
// Dispatch stage: checks a decoded instruction against the register status
// tables and the functional-unit occupancy, then issues it with source tags.
// Ports:
//   CLK, nRST                  : clock, async active-low reset
//   in_valid/in_fu/in_wen      : decoded instruction, target unit, writes-dest
//   in_rd/in_rs1/in_rs2        : scalar dest / sources
//   in_md/in_ms1/in_ms2/in_ms3 : matrix dest / sources
//   fu_busy                    : per-unit station occupied
//   freeze, flush              : hold outputs / clear tables and disp_en
//   wb_s_*, wb_m_*             : scalar and matrix writeback (clear on tag match)
//   in_ready                   : combinational accept
//   disp_en/disp_fu/disp_t1..3/disp_instr : registered dispatch, valid the
//                                cycle after accept
module dispatch
  import datapath_pkg::*;
(
  input  logic               CLK,
  input  logic               nRST,
  input  logic               in_valid,
  input  logic [2:0]         in_fu,
  input  logic               in_wen,
  input  logic [S_IDX_W-1:0] in_rd,
  input  logic [S_IDX_W-1:0] in_rs1,
  input  logic [S_IDX_W-1:0] in_rs2,
  input  logic [M_IDX_W-1:0] in_md,
  input  logic [M_IDX_W-1:0] in_ms1,
  input  logic [M_IDX_W-1:0] in_ms2,
  input  logic [M_IDX_W-1:0] in_ms3,
  input  logic [NUM_FU-1:0]  fu_busy,
  input  logic               freeze,
  input  logic               flush,
  input  logic               wb_s_en,
  input  logic [S_IDX_W-1:0] wb_s_rd,
  input  tag_t               wb_s_tag,
  input  logic               wb_m_en,
  input  logic [M_IDX_W-1:0] wb_m_rd,
  input  tag_t               wb_m_tag,
  output logic               in_ready,
  output logic               disp_en,
  output logic [2:0]         disp_fu,
  output tag_t               disp_t1,
  output tag_t               disp_t2,
  output tag_t               disp_t3,
  output disp_pkt_t          disp_instr
);

  logic       fu_valid, is_matrix, waw_stall, struct_stall, accept;
  logic       s_dest_busy, m_dest_busy;
  logic       last_en;
  logic [2:0] last_fu;
  logic [7:0] busy_ext;
  tag_t       new_tag, src_t1, src_t2, src_t3;
  tag_t       s_rs1_tag, s_rs2_tag, s_unused_tag;
  tag_t       m_ms1_tag, m_ms2_tag, m_ms3_tag;
  disp_pkt_t  pkt;

  assign fu_valid  = (in_fu <= FU_GEMM);
  assign is_matrix = fu_is_matrix(in_fu);
  assign new_tag   = fu_tag(in_fu);

  // Indices 5-7 read as busy so an invalid unit can never look free.
  assign busy_ext     = {3'b111, fu_busy};
  assign struct_stall = busy_ext[in_fu] | (last_en & (last_fu == in_fu));
  assign waw_stall    = in_wen & (is_matrix ? m_dest_busy : s_dest_busy);
  assign in_ready     = ~freeze & ~flush & fu_valid & ~waw_stall & ~struct_stall;
  assign accept       = in_valid & in_ready;

  assign pkt = '{wen: in_wen, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                 md: in_md, ms1: in_ms1, ms2: in_ms2, ms3: in_ms3};

  always_comb begin
    src_t1 = '0;
    src_t2 = '0;
    src_t3 = '0;
    case (in_fu)
      FU_MLDST: src_t1 = s_rs1_tag;  // address base only
      FU_GEMM: begin
        src_t1 = m_ms1_tag;
        src_t2 = m_ms2_tag;
        src_t3 = m_ms3_tag;
      end
      default: begin
        src_t1 = s_rs1_tag;
        src_t2 = s_rs2_tag;
      end
    endcase
  end

  // Scalar side needs only two source ports; the third is parked on x0.
  reg_status_table #(.DEPTH(S_DEPTH), .IDX_W(S_IDX_W), .ZERO_REG(1'b1)) u_scalar (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .ra_idx(in_rs1), .rb_idx(in_rs2), .rc_idx('0),
    .ra_tag(s_rs1_tag), .rb_tag(s_rs2_tag), .rc_tag(s_unused_tag),
    .set_en(accept & in_wen & ~is_matrix), .set_idx(in_rd), .set_tag(new_tag),
    .set_busy(s_dest_busy),
    .clr_en(wb_s_en), .clr_idx(wb_s_rd), .clr_tag(wb_s_tag)
  );

  reg_status_table #(.DEPTH(M_DEPTH), .IDX_W(M_IDX_W), .ZERO_REG(1'b0)) u_matrix (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .ra_idx(in_ms1), .rb_idx(in_ms2), .rc_idx(in_ms3),
    .ra_tag(m_ms1_tag), .rb_tag(m_ms2_tag), .rc_tag(m_ms3_tag),
    .set_en(accept & in_wen & is_matrix), .set_idx(in_md), .set_tag(new_tag),
    .set_busy(m_dest_busy),
    .clr_en(wb_m_en), .clr_idx(wb_m_rd), .clr_tag(wb_m_tag)
  );

  // last_* tracks real accepts independently of the frozen disp_* outputs,
  // so a held disp_en never extends the structural stall.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last_en    <= 1'b0;
      last_fu    <= '0;
      disp_en    <= 1'b0;
      disp_fu    <= '0;
      disp_t1    <= '0;
      disp_t2    <= '0;
      disp_t3    <= '0;
      disp_instr <= '0;
    end else begin
      last_en <= accept;
      last_fu <= in_fu;
      if (flush) begin
        disp_en <= 1'b0;
      end else if (!freeze) begin
        disp_en <= accept;
        if (accept) begin
          disp_fu    <= in_fu;
          disp_t1    <= src_t1;
          disp_t2    <= src_t2;
          disp_t3    <= src_t3;
          disp_instr <= pkt;
        end
      end
    end
  end

endmodule
